stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//   Parametrised 1-to-NUM_OUT stream demultiplexer with a valid/ready handshake and a registered output.
//   Each input beat goes to the output channel chosen by s_sel.
//   In packet mode the channel is fixed at the first beat and held until s_last.
//   Sits between a single producer and NUM_OUT consumer streams; replaces the combinational 1-to-8 demux.
// PARAMETERS
//   DATA_W    8   payload width in bits (>=1)
//   NUM_OUT   8   number of output channels (2..256)
//   PKT_MODE  1   1 = select locked per packet (first beat to s_last); 0 = select evaluated every beat
//   SEL_W     derived localparam = $clog2(NUM_OUT); not overridable
// PORTS
//   clk      in   1              rising-edge clock
//   rst      in   1              asynchronous, active-high reset
//   s_valid  in   1              input beat valid
//   s_ready  out  1              input beat accepted when s_valid && s_ready
//   s_data   in   DATA_W         input payload
//   s_sel    in   SEL_W          destination channel index
//   s_last   in   1              final beat of packet (ignored when PKT_MODE=0)
//   m_valid  out  NUM_OUT        one-hot output valid, bit i = channel i
//   m_ready  in   NUM_OUT        per-channel ready
//   m_data   out  DATA_W         shared output payload, qualified by m_valid
//   m_last   out  1              shared last flag, qualified by m_valid
//   err      out  1              one-cycle pulse: beat with invalid select was dropped
//   busy     out  1              high while the FSM is not in IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; o_vld=0; m_valid=0; m_data=0; m_last=0; err=0; busy=0.
//     Reset mid-packet discards the held beat and the locked select.
//   Output register: o_vld, o_dest, o_data, o_last.
//     m_valid = o_vld ? (1<<o_dest) : 0. At most one m_valid bit is ever high.
//   Ready: s_ready = !o_vld || m_ready[o_dest], except in DROP, where s_ready=1.
//     s_ready is combinational from m_ready. Full throughput: one beat/cycle when the target is ready.
//   Output handshake: a beat leaves on a cycle with o_vld && m_ready[o_dest].
//     The beat accepted on the same edge loads the register, so there is no bubble.
//   Latency: a beat accepted at edge k drives m_* from edge k onward. One register stage.
//   m_data and m_last are stable while o_vld=1 and the target is not ready.
//   FSM states:
//     IDLE: on accept, eff_sel = s_sel.
//       Valid select: load register, o_dest = s_sel.
//         If PKT_MODE=1 and !s_last: lock_sel <= s_sel, go to LOCK.
//       Invalid select (s_sel >= NUM_OUT): beat dropped, output register unchanged, err=1 next cycle.
//         If PKT_MODE=1 and !s_last: go to DROP.
//     LOCK: s_sel ignored; accepted beats load with o_dest = lock_sel.
//       Accept with s_last: go to IDLE.
//     DROP: every s_valid beat is consumed and discarded, with no further err pulses.
//       Accept with s_last: go to IDLE.
//   PKT_MODE=0: the FSM never leaves IDLE; s_last is passed to m_last untouched; invalid select drops a single beat.
//   Single-beat packet (s_last on first beat): stays in IDLE.
//   Back-pressure on the locked channel stalls input. Other channels' m_ready have no effect.
//   Select changes while s_valid=1 && !s_ready: no constraint. The value sampled on the accept edge is used.
//   err is registered: high exactly one cycle after the dropping accept edge.
// TESTING
//   1 Sweep (NUM_OUT=8, PKT_MODE=0, all m_ready=1): s_data=8'hA0+i, s_sel=i for i=0..7 on back-to-back cycles
//     -> m_valid=8'h01,02,..,80 on consecutive cycles with m_data=A0..A7; s_ready stays 1.
//   2 Back-pressure: send to sel=3 with m_ready[3]=0 for 5 cycles
//     -> m_valid=8'h08 held and m_data stable; s_ready=0 for 5 cycles; second beat delivered the cycle after release.
//   3 Packet lock (PKT_MODE=1): 4-beat packet, s_sel=5 on beat 0 and s_sel=2 on beats 1..3, s_last on beat 3
//     -> all 4 beats on m_valid[5]; busy=1 from beat 1 to beat 3; next packet honours its own s_sel.
//   4 Invalid select (NUM_OUT=6): 3-beat packet with s_sel=7
//     -> err pulses once; no m_valid; s_ready=1 throughout; FSM returns to IDLE after beat 3.
//   5 Reset mid-packet: assert rst asynchronously between edges during LOCK with o_vld=1
//     -> m_valid=0, busy=0 immediately; the next packet routes by its own s_sel.
//   6 Random: valid/ready toggling, 2000 beats -> per-channel order and payload match a reference queue model.

Source files
------------

// File: rtl/stream_demux.sv
// 1-to-NUM_OUT valid/ready stream demultiplexer with a single registered output stage.
// In packet mode the destination is captured on the first beat and held until s_last.
module stream_demux #(
    parameter int DATA_W   = 8,
    parameter int NUM_OUT  = 8,
    parameter int PKT_MODE = 1,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    input  logic [SEL_W-1:0]     s_sel,
    input  logic                 s_last,
    output logic [NUM_OUT-1:0]   m_valid,
    input  logic [NUM_OUT-1:0]   m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    output logic                 err,
    output logic                 busy
);

    localparam int              EXT_W     = 1 << SEL_W;
    localparam logic [SEL_W:0]  NUM_OUT_C = (SEL_W + 1)'(NUM_OUT);
    localparam bit              PKT_C     = (PKT_MODE != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                o_vld_r;
    logic [SEL_W-1:0]    o_dest_r;
    logic [DATA_W-1:0]   o_data_r;
    logic                o_last_r;
    logic [SEL_W-1:0]    lock_sel_r;
    logic                err_r;

    logic [EXT_W-1:0]    m_ready_ext_s;
    logic [EXT_W-1:0]    m_valid_ext_s;
    logic                tgt_ready_s;
    logic [SEL_W-1:0]    eff_sel_s;
    logic                sel_ok_s;
    logic                s_ready_s;
    logic                busy_s;
    logic                accept_s;
    logic                load_s;
    logic                drop_s;
    logic                out_fire_s;

    // Channel decode: widen to a power of two so o_dest_r indexes without range issues
    always_comb begin
        m_ready_ext_s = '0;
        m_valid_ext_s = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            m_ready_ext_s[i] = m_ready[i];
        end
        m_valid_ext_s[o_dest_r] = o_vld_r;
        tgt_ready_s = m_ready_ext_s[o_dest_r];
    end

    // Datapath qualifiers for the current cycle
    always_comb begin
        eff_sel_s  = (state_r == ST_LOCK) ? lock_sel_r : s_sel;
        sel_ok_s   = ({1'b0, eff_sel_s} < NUM_OUT_C);
        accept_s   = s_valid && s_ready_s;
        load_s     = accept_s && (state_r != ST_DROP) && sel_ok_s;
        drop_s     = accept_s && (state_r == ST_IDLE) && !sel_ok_s;
        out_fire_s = o_vld_r && tgt_ready_s;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && PKT_C && !s_last) begin
                    state_nxt_s = sel_ok_s ? ST_LOCK : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCK, ST_DROP: begin
                if (accept_s && s_last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the drop state swallows beats regardless of downstream readiness
    always_comb begin
        s_ready_s = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_ready_s = !o_vld_r || tgt_ready_s;
                busy_s    = 1'b0;
            end
            ST_LOCK: begin
                s_ready_s = !o_vld_r || tgt_ready_s;
                busy_s    = 1'b1;
            end
            ST_DROP: begin
                s_ready_s = 1'b1;
                busy_s    = 1'b1;
            end
            default: begin
                s_ready_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Output stage: a new beat may load on the same edge the held beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld_r  <= 1'b0;
            o_dest_r <= '0;
            o_data_r <= '0;
            o_last_r <= 1'b0;
        end else if (load_s) begin
            o_vld_r  <= 1'b1;
            o_dest_r <= eff_sel_s;
            o_data_r <= s_data;
            o_last_r <= s_last;
        end else if (out_fire_s) begin
            o_vld_r  <= 1'b0;
        end
    end

    // Packet select capture and drop indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sel_r <= '0;
            err_r      <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && accept_s && sel_ok_s) begin
                lock_sel_r <= s_sel;
            end
            err_r <= drop_s;
        end
    end

    assign s_ready = s_ready_s;
    assign busy    = busy_s;
    assign m_valid = m_valid_ext_s[NUM_OUT-1:0];
    assign m_data  = o_data_r;
    assign m_last  = o_last_r;
    assign err     = err_r;

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: one streaming instance (8 ch) and one packet instance (6 ch).
module tb_stream_demux;

    typedef struct packed {
        logic [7:0] chan;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic [2:0] s_sel;
    logic       s_last;

    logic       s_valid_str, s_ready_str, m_last_str, err_str, busy_str;
    logic [7:0] m_valid_str, m_ready_str, m_data_str;
    logic       s_valid_pkt, s_ready_pkt, m_last_pkt, err_pkt, busy_pkt;
    logic [5:0] m_valid_pkt, m_ready_pkt;
    logic [7:0] m_data_pkt;

    int    n_vec;
    int    n_err;
    int    err_cnt;
    beat_t q_str[$];
    beat_t q_pkt[$];
    logic [7:0] prev_mv[2];
    logic [7:0] prev_md[2];
    logic       prev_ml[2];
    logic       prev_stall[2];

    stream_demux #(.DATA_W(8), .NUM_OUT(8), .PKT_MODE(0)) u_str (
        .clk(clk), .rst(rst),
        .s_valid(s_valid_str), .s_ready(s_ready_str), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid_str), .m_ready(m_ready_str), .m_data(m_data_str), .m_last(m_last_str),
        .err(err_str), .busy(busy_str)
    );

    stream_demux #(.DATA_W(8), .NUM_OUT(6), .PKT_MODE(1)) u_pkt (
        .clk(clk), .rst(rst),
        .s_valid(s_valid_pkt), .s_ready(s_ready_pkt), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
        .m_valid(m_valid_pkt), .m_ready(m_ready_pkt), .m_data(m_data_pkt), .m_last(m_last_pkt),
        .err(err_pkt), .busy(busy_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int d, input logic [7:0] mv, input logic [7:0] mr,
                       input logic [7:0] md, input logic ml);
        logic [7:0] fire;
        beat_t      e;
        fire = mv & mr;
        if (rst) begin
            prev_stall[d] = 1'b0;
        end else begin
            if (prev_stall[d]) begin
                check("stall_valid", 32'(mv), 32'(prev_mv[d]));
                check("stall_data", 32'(md), 32'(prev_md[d]));
                check("stall_last", 32'(ml), 32'(prev_ml[d]));
            end
            if (fire != 8'h00) begin
                if ((d == 0 && q_str.size() == 0) || (d == 1 && q_pkt.size() == 0)) begin
                    check("unexpected_beat", 32'(fire), 32'h0);
                end else begin
                    e = (d == 0) ? q_str.pop_front() : q_pkt.pop_front();
                    check("out_chan", 32'(mv), 32'(8'b1 << e.chan));
                    check("out_data", 32'(md), 32'(e.data));
                    check("out_last", 32'(ml), 32'(e.last));
                end
            end
            prev_stall[d] = (mv != 8'h00) && (fire == 8'h00);
            prev_mv[d]    = mv;
            prev_md[d]    = md;
            prev_ml[d]    = ml;
        end
    endtask

    // Monitor: pops the scoreboard whenever an output handshake will complete on the next edge
    always @(negedge clk) begin
        mon(0, m_valid_str, m_ready_str, m_data_str, m_last_str);
        mon(1, {2'b00, m_valid_pkt}, {2'b00, m_ready_pkt}, m_data_pkt, m_last_pkt);
        if (err_pkt) err_cnt++;
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for acceptance, records the expected output
    task automatic send(input int d, input int sel, input int data, input bit last,
                        input int exp_chan, input int exp_busy, output int waits);
        logic rdy;
        logic bsy;
        s_sel  = 3'(sel);
        s_data = 8'(data);
        s_last = last;
        if (d == 0) s_valid_str = 1'b1; else s_valid_pkt = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            rdy = (d == 0) ? s_ready_str : s_ready_pkt;
            bsy = (d == 0) ? busy_str : busy_pkt;
            if (exp_busy >= 0 && waits == 0) check("busy", 32'(bsy), 32'(exp_busy));
            if (rdy) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        sync();
        if (waits <= 200 && exp_chan >= 0) begin
            if (d == 0) q_str.push_back('{8'(exp_chan), 8'(data), last});
            else        q_pkt.push_back('{8'(exp_chan), 8'(data), last});
        end
        s_valid_str = 1'b0;
        s_valid_pkt = 1'b0;
    endtask

    initial begin
        int w;
        int err0;
        int exp_drops;
        bit rand_done;
        n_vec = 0; n_err = 0; err_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            prev_stall[i] = 1'b0; prev_mv[i] = 8'h00; prev_md[i] = 8'h00; prev_ml[i] = 1'b0;
        end
        rst = 1'b1;
        s_data = 8'h00; s_sel = 3'd0; s_last = 1'b0;
        s_valid_str = 1'b0; s_valid_pkt = 1'b0;
        m_ready_str = 8'hFF; m_ready_pkt = 6'h3F;

        // Reset state
        @(negedge clk);
        check("rst_mvalid_str", 32'(m_valid_str), 32'h0);
        check("rst_mdata_str", 32'(m_data_str), 32'h0);
        check("rst_mlast_str", 32'(m_last_str), 32'h0);
        check("rst_sready_str", 32'(s_ready_str), 32'h1);
        check("rst_mvalid_pkt", 32'(m_valid_pkt), 32'h0);
        check("rst_err_pkt", 32'(err_pkt), 32'h0);
        check("rst_busy_pkt", 32'(busy_pkt), 32'h0);
        @(posedge clk); #3 rst = 1'b0;
        sync();

        // Sweep all eight channels back to back
        for (int i = 0; i < 8; i++) begin
            send(0, i, 8'hA0 + i, i[0], i, 0, w);
            check("sweep_ready", 32'(w), 32'd0);
        end
        repeat (3) sync();

        // Back-pressure on channel 3
        m_ready_str = 8'hF7;
        send(0, 3, 8'h55, 1'b0, 3, 0, w);
        s_valid_str = 1'b1; s_sel = 3'd3; s_data = 8'h66; s_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_sready", 32'(s_ready_str), 32'h0);
            check("bp_mvalid", 32'(m_valid_str), 32'h08);
            check("bp_mdata", 32'(m_data_str), 32'h55);
            sync();
        end
        m_ready_str = 8'hFF;
        @(negedge clk);
        check("bp_release_ready", 32'(s_ready_str), 32'h1);
        sync();
        q_str.push_back('{8'd3, 8'h66, 1'b1});
        s_valid_str = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(m_valid_str), 32'h08);
        check("bp_second_data", 32'(m_data_str), 32'h66);
        sync();

        // Packet lock: select changes after beat 0 are ignored
        send(1, 5, 8'h30, 1'b0, 5, 0, w);
        send(1, 2, 8'h31, 1'b0, 5, 1, w);
        send(1, 2, 8'h32, 1'b0, 5, 1, w);
        send(1, 2, 8'h33, 1'b1, 5, 1, w);
        send(1, 2, 8'h40, 1'b1, 2, 0, w);
        repeat (2) sync();

        // Invalid select packet is swallowed with a single err pulse
        err0 = err_cnt;
        send(1, 7, 8'h70, 1'b0, -1, 0, w);
        check("drop_ready0", 32'(w), 32'd0);
        @(negedge clk);
        check("drop_err_pulse", 32'(err_pkt), 32'h1);
        sync();
        send(1, 1, 8'h71, 1'b0, -1, 1, w);
        check("drop_ready1", 32'(w), 32'd0);
        send(1, 7, 8'h72, 1'b1, -1, 1, w);
        check("drop_ready2", 32'(w), 32'd0);
        @(negedge clk);
        check("drop_err_low", 32'(err_pkt), 32'h0);
        check("drop_idle", 32'(busy_pkt), 32'h0);
        check("drop_err_count", 32'(err_cnt - err0), 32'd1);
        sync();

        // Asynchronous reset in the middle of a stalled packet
        m_ready_pkt = 6'h00;
        send(1, 4, 8'h44, 1'b0, -1, 0, w);
        @(negedge clk);
        check("pre_rst_mvalid", 32'(m_valid_pkt), 32'h10);
        check("pre_rst_busy", 32'(busy_pkt), 32'h1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("rst_async_mvalid", 32'(m_valid_pkt), 32'h0);
        check("rst_async_busy", 32'(busy_pkt), 32'h0);
        @(posedge clk); #3 rst = 1'b0;
        sync();
        m_ready_pkt = 6'h3F;
        send(1, 1, 8'h51, 1'b1, 1, 0, w);
        repeat (2) sync();

        // Random traffic against a reference packet model
        err0 = err_cnt;
        exp_drops = 0;
        rand_done = 1'b0;
        fork
            begin
                bit in_pkt;
                int lock_ch;
                in_pkt = 1'b0;
                lock_ch = 0;
                for (int i = 0; i < 2000; i++) begin
                    int sel;
                    int ch;
                    bit lst;
                    int w2;
                    if ($urandom_range(2) == 0) sync();
                    sel = int'($urandom_range(7));
                    lst = ($urandom_range(3) == 0);
                    if (!in_pkt) begin
                        ch = (sel < 6) ? sel : -1;
                        if (ch < 0) exp_drops++;
                        lock_ch = ch;
                        in_pkt = !lst;
                    end else begin
                        ch = lock_ch;
                        in_pkt = !lst;
                    end
                    send(1, sel, int'($urandom_range(255)), lst, ch, -1, w2);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    m_ready_pkt = 6'($urandom);
                end
            end
        join
        m_ready_pkt = 6'h3F;
        for (int k = 0; k < 100 && (q_pkt.size() != 0 || q_str.size() != 0); k++) sync();
        check("drain_empty", 32'(q_pkt.size() + q_str.size()), 32'd0);
        check("rand_err_count", 32'(err_cnt - err0), 32'(exp_drops));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
